// File: rtl/mult32u_mac_sequencer_if.sv
// Signal bundle for the MAC sequencer: burst control, operand stream,
// multiplier wrapper connection and burst result.
interface mult32u_mac_sequencer_if #(
    parameter int ACC_W = 80,
    parameter int LEN_W = 16
);
    logic             start;
    logic [LEN_W-1:0] burst_len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic [63:0]      mul_product;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_overflow;

    modport slave (
        input  start, burst_len, in_valid, in_a, in_b, mul_product, out_ready,
        output busy, in_ready, mul_a, mul_b, out_valid, out_acc, out_overflow
    );

    modport master (
        output start, burst_len, in_valid, in_a, in_b, mul_product, out_ready,
        input  busy, in_ready, mul_a, mul_b, out_valid, out_acc, out_overflow
    );
endinterface

// File: rtl/mult32u_mac_sequencer.sv
// Burst multiply-accumulate controller around a registered 32x32 multiplier.
// Define MULT32U_MAC_SATURATE_EN to clamp the accumulator instead of wrapping.
module mult32u_mac_sequencer #(
    parameter int MUL_LATENCY = 2,
    parameter int ACC_W       = 80,
    parameter int LEN_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    mult32u_mac_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_stateNext;
    logic [LEN_W-1:0]       r_remaining;
    logic [LEN_W-1:0]       w_remainingNext;
    logic [ACC_W-1:0]       r_acc;
    logic [ACC_W-1:0]       w_accNext;
    logic                   r_ovf;
    logic                   w_ovfNext;
    logic [MUL_LATENCY-1:0] r_tag;
    logic [MUL_LATENCY-1:0] w_tagNext;
    logic                   w_inReady;
    logic                   w_fire;
    logic [ACC_W:0]         w_sum;

    assign w_inReady = (r_state == S_ISSUE);
    assign w_fire    = bus.in_valid && w_inReady;
    assign w_sum     = {1'b0, r_acc} + {{(ACC_W + 1 - 64){1'b0}}, bus.mul_product};

    assign bus.mul_a        = bus.in_a;
    assign bus.mul_b        = bus.in_b;
    assign bus.in_ready     = w_inReady;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.out_valid    = (r_state == S_DONE);
    assign bus.out_acc      = r_acc;
    assign bus.out_overflow = r_ovf;

    always_comb begin
        w_stateNext     = r_state;
        w_remainingNext = r_remaining;
        w_accNext       = r_acc;
        w_ovfNext       = r_ovf;
        w_tagNext       = '0;

        // Each tag marks an accepted pair; when it leaves the last stage the
        // wrapper output holds that pair's product.
        w_tagNext[0] = w_fire;
        for (int i = 1; i < MUL_LATENCY; i++) begin
            w_tagNext[i] = r_tag[i-1];
        end

        if (r_tag[MUL_LATENCY-1]) begin
`ifdef MULT32U_MAC_SATURATE_EN
            if (w_sum[ACC_W]) begin
                w_accNext = '1;
                w_ovfNext = 1'b1;
            end else begin
                w_accNext = w_sum[ACC_W-1:0];
            end
`else
            w_accNext = w_sum[ACC_W-1:0];
            if (w_sum[ACC_W]) begin
                w_ovfNext = 1'b1;
            end
`endif
        end

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accNext = '0;
                    w_ovfNext = 1'b0;
                    if (bus.burst_len != '0) begin
                        w_remainingNext = bus.burst_len;
                        w_stateNext     = S_ISSUE;
                    end else begin
                        w_stateNext     = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                if (w_fire) begin
                    w_remainingNext = r_remaining - LEN_W'(1);
                    if (r_remaining == LEN_W'(1)) begin
                        w_stateNext = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (r_tag == '0) begin
                    w_stateNext = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Clearing the tags on reset is what discards products still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_tag       <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_remaining <= w_remainingNext;
            r_acc       <= w_accNext;
            r_ovf       <= w_ovfNext;
            r_tag       <= w_tagNext;
        end
    end
endmodule
